// File: rtl/fir_stream_ctrl_if.sv
// Stream handshake bundle for fir_stream_ctrl.
// Sample in (valid/ready/data) and result out (valid/ready/data).
interface fir_stream_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Valid/ready sequencer for a single-enable FIR with zero-flush.
// Ports: clk, rst (sync, high), s (stream if), flush/flush_done,
//   busy, fir_en/fir_data_in/fir_data_out to the FIR.
// Option: FIR_STREAM_CTRL_TAIL_EN emits the convolution tail on flush.
module fir_stream_ctrl #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 9,
  parameter int NUM_TAPS = 4,
  parameter int LATENCY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  fir_stream_ctrl_if.slave  s,
  input  logic              flush,
  output logic              flush_done,
  output logic              busy,
  output logic              fir_en,
  output logic [DATA_W-1:0] fir_data_in,
  input  logic [OUT_W-1:0]  fir_data_out
);

  localparam int F  = NUM_TAPS + LATENCY - 1;
  localparam int CW = $clog2(F + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [LATENCY-1:0] vld_pipe, vld_nxt;
  logic [LATENCY:0]   vld_ext;
  logic [CW-1:0]      flush_cnt, cnt_nxt;
  logic               done_nxt;
  logic               slot_free;
  logic               rdy;
  logic               ins_bit;
  logic               tail_bit;

`ifdef FIR_STREAM_CTRL_TAIL_EN
  // First NUM_TAPS-1 flush advances carry the tail.
  assign tail_bit = (flush_cnt > CW'(LATENCY));
`else
  assign tail_bit = 1'b0;
`endif

  assign s.out_valid = vld_pipe[LATENCY-1];
  assign s.out_data  = fir_data_out;
  assign s.in_ready  = rdy;
  assign slot_free   = !s.out_valid || s.out_ready;
  assign busy        = (state == FLUSH) || (|vld_pipe);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = flush_cnt;
    done_nxt    = 1'b0;
    rdy         = 1'b0;
    fir_en      = 1'b0;
    fir_data_in = '0;
    ins_bit     = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        rdy         = slot_free && !flush;
        fir_en      = s.in_valid && rdy;
        fir_data_in = s.in_data;
        ins_bit     = 1'b1;
        if (flush) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(F);
        end
      end
      (state == FLUSH): begin
        fir_en  = slot_free;
        ins_bit = tail_bit;
        if (fir_en) begin
          cnt_nxt = flush_cnt - 1'b1;
          if (flush_cnt == CW'(1)) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
    // Slots move with the FIR; a consumed result
    // with no advance leaves an empty output slot.
    vld_ext = {vld_pipe, ins_bit};
    vld_nxt = vld_pipe;
    if (fir_en)
      vld_nxt = vld_ext[LATENCY-1:0];
    else if (s.out_valid && s.out_ready)
      vld_nxt[LATENCY-1] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      vld_pipe   <= '0;
      flush_cnt  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      vld_pipe   <= vld_nxt;
      flush_cnt  <= cnt_nxt;
      flush_done <= done_nxt;
    end
  end

endmodule
